serving_uart_tx: RTL

Wishbone-slave UART transmitter for the serving SoC's external peripheral region. It consumes the external-port Wishbone transaction produced by the SoC bus mux for addresses with adr[31:30] != 2'b00. Bytes written by the CPU are queued in a small FIFO and shifted out serially as 8N1 frames. A status register exposes FIFO level, busy and a sticky overflow flag.

---
 rtl/serving_uart_tx.sv | 97 +++++++++
 1 files changed

// File: rtl/serving_uart_tx.sv
// serving_uart_tx: Wishbone-slave 8N1 UART transmitter with a byte FIFO and status register.
// Holds a small queue of CPU-written bytes and shifts each out LSB-first between start and stop bits.
module serving_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [AW:0] wp, rp, level;
  logic [7:0] mem [FIFO_DEPTH];
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic ovf, taken, wr_data, full, empty, push, pop, tick;
  logic [31:0] status;
  logic unused;
  assign unused  = ^{i_wb_adr[31:3], i_wb_adr[1:0], i_wb_dat[31:8], i_wb_sel[3:1]};
  assign taken   = i_wb_stb & ~o_wb_ack;
  assign wr_data = taken & i_wb_we & ~i_wb_adr[2] & i_wb_sel[0];
  assign level   = wp - rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = wp == rp;
  // A full FIFO rejects the push even if the shifter pops in the same cycle.
  assign push    = wr_data & ~full;
  assign pop     = (state == IDLE) & ~empty;
  assign tick    = cnt == '0;
  assign status  = {16'd0, 8'(level), 4'd0, ovf, state != IDLE, empty, full};
  assign o_tx    = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  always_ff @(posedge i_clk) begin
    if (push) mem[wp[AW-1:0]] <= i_wb_dat[7:0];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      wp       <= '0;
      rp       <= '0;
      ovf      <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
    end else begin
      o_wb_ack <= taken;
      o_wb_rdt <= (taken & ~i_wb_we & i_wb_adr[2]) ? status : 32'd0;
      wp       <= wp + (AW+1)'(push);
      rp       <= rp + (AW+1)'(pop);
      if (wr_data & full) ovf <= 1'b1;
      else if (taken & i_wb_we & i_wb_adr[2] & i_wb_dat[3]) ovf <= 1'b0;
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = tick ? RELOAD : cnt - 1'b1;
    idx_n   = idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (!empty) begin
          state_n = START;
          cnt_n   = RELOAD;
          shift_n = mem[rp[AW-1:0]];
        end
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        idx_n   = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: state_n = tick ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule
